maxpool_stream: RTL and testbench

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

---
 rtl/maxpool_stream.sv | 198 +++++++++++++++++++
 tb/tb_maxpool_stream.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// maxpool_stream
//   Streaming per-channel max pooling. Each accepted beat carries one window
//   element for every lane; after WIN beats the per-lane maximum is presented
//   on a registered output with a valid/ready handshake.
//
// Parameters
//   DATA_W  element width in bits
//   WIN     elements per pooling window (1..256)
//   CH      number of lanes pooled in parallel
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   in_valid     in_data carries one element per lane
//   in_ready     beat is accepted this cycle (= !out_valid || out_ready)
//   in_data      lane k at [k*DATA_W +: DATA_W]
//   signed_mode  1: two's-complement compare, 0: unsigned (sampled on first beat)
//   out_valid    out_data holds a completed window result
//   out_ready    consumer takes the result this cycle
//   out_data     per-lane window maximum, same packing as in_data
//   out_idx      per-lane position of the first maximum (MAXPOOL_ARGMAX_EN only)
//
// Configuration macro
//   MAXPOOL_ARGMAX_EN  adds per-lane index tracking and the out_idx port.
module maxpool_stream #(
    parameter int  DATA_W = 8,
    parameter int  WIN    = 9,
    parameter int  CH     = 4,
    localparam int IDX_W  = (WIN > 1) ? $clog2(WIN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [CH*IDX_W-1:0]  out_idx
`endif
);

    typedef enum logic {
        ST_START = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t               w_state;
    logic [IDX_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     w_cnt_nxt;
    logic                 r_mode;
    logic                 w_mode;
    logic                 w_accept;
    logic                 w_last;
    logic [CH-1:0]        w_take;
    logic [DATA_W-1:0]    w_in      [CH];
    logic [DATA_W-1:0]    r_acc     [CH];
    logic [DATA_W-1:0]    w_acc_nxt [CH];
    logic [CH*DATA_W-1:0] w_out_nxt;
    logic                 r_out_valid;
    logic [CH*DATA_W-1:0] r_out_data;

    // Strict greater-than under the selected number format.
    function automatic logic f_greater(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input logic              is_signed);
        logic res;
        if (is_signed) begin
            res = ($signed(a) > $signed(b));
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

    // The output register can always be refilled when it is empty or being drained.
    assign in_ready  = !r_out_valid || out_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Window state decode, per-lane select and counter advance.
    always_comb begin
        w_state   = (r_cnt == IDX_W'(0)) ? ST_START : ST_ACCUM;
        w_accept  = in_valid && in_ready;
        w_last    = (r_cnt == IDX_W'(WIN - 1));
        w_mode    = r_mode;
        w_take    = {CH{1'b0}};
        w_out_nxt = {(CH*DATA_W){1'b0}};
        for (int k = 0; k < CH; k++) begin
            w_in[k]      = in_data[k*DATA_W +: DATA_W];
            w_acc_nxt[k] = r_acc[k];
        end
        case (w_state)
            // First element of a window: load unconditionally and latch the mode.
            ST_START: begin
                w_mode = signed_mode;
                w_take = {CH{1'b1}};
            end
            // Later elements: replace only on strictly greater, so ties keep the earlier one.
            ST_ACCUM: begin
                w_mode = r_mode;
                for (int k = 0; k < CH; k++) begin
                    w_take[k] = f_greater(w_in[k], r_acc[k], r_mode);
                end
            end
            default: begin
                w_mode = r_mode;
                w_take = {CH{1'b0}};
            end
        endcase
        for (int k = 0; k < CH; k++) begin
            if (w_take[k]) begin
                w_acc_nxt[k] = w_in[k];
            end else begin
                w_acc_nxt[k] = r_acc[k];
            end
            w_out_nxt[k*DATA_W +: DATA_W] = w_acc_nxt[k];
        end
        if (w_last) begin
            w_cnt_nxt = IDX_W'(0);
        end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
        end
    end

    // Window accumulation: element counter, latched mode and per-lane running maxima.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= IDX_W'(0);
            r_mode <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                r_acc[k] <= DATA_W'(0);
            end
        end else if (w_accept) begin
            r_cnt  <= w_cnt_nxt;
            r_mode <= w_mode;
            for (int k = 0; k < CH; k++) begin
                r_acc[k] <= w_acc_nxt[k];
            end
        end
    end

    // Result register: load on the last beat of a window, clear when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {(CH*DATA_W){1'b0}};
        end else if (w_accept && w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MAXPOOL_ARGMAX_EN
    logic [IDX_W-1:0]    r_idx     [CH];
    logic [IDX_W-1:0]    w_idx_nxt [CH];
    logic [CH*IDX_W-1:0] w_oidx_nxt;
    logic [CH*IDX_W-1:0] r_out_idx;

    assign out_idx = r_out_idx;

    // Index follows the element selection; r_cnt is 0 on a window's first beat.
    always_comb begin
        w_oidx_nxt = {(CH*IDX_W){1'b0}};
        for (int k = 0; k < CH; k++) begin
            if (w_take[k]) begin
                w_idx_nxt[k] = r_cnt;
            end else begin
                w_idx_nxt[k] = r_idx[k];
            end
            w_oidx_nxt[k*IDX_W +: IDX_W] = w_idx_nxt[k];
        end
    end

    // Per-lane index registers and the registered index output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_idx <= {(CH*IDX_W){1'b0}};
            for (int k = 0; k < CH; k++) begin
                r_idx[k] <= IDX_W'(0);
            end
        end else if (w_accept) begin
            for (int k = 0; k < CH; k++) begin
                r_idx[k] <= w_idx_nxt[k];
            end
            if (w_last) begin
                r_out_idx <= w_oidx_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream. Four instances cover the window sizes
// of interest: A (WIN=9, CH=4), B (WIN=4, CH=1), C (WIN=3, CH=1) and
// D (WIN=1, CH=4). Stimulus pushes hand-computed results into per-instance
// queues; monitors compare whatever the DUT presents on the falling edge.
module tb_maxpool_stream;

    logic clk = 1'b0;
    logic rst_n;
    bit   mon_en = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   d_pops  = 0;

    logic        a_in_valid, a_in_ready, a_sm, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_sm, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic        c_in_valid, c_in_ready, c_sm, c_out_valid, c_out_ready;
    logic [7:0]  c_in_data, c_out_data;
    logic        d_in_valid, d_in_ready, d_sm, d_out_valid, d_out_ready;
    logic [31:0] d_in_data, d_out_data;
`ifdef MAXPOOL_ARGMAX_EN
    logic [15:0] a_out_idx;
    logic [1:0]  b_out_idx;
    logic [1:0]  c_out_idx;
    logic [3:0]  d_out_idx;
`endif

    logic [31:0] a_qd[$];
    logic [15:0] a_qi[$];
    logic [7:0]  b_qd[$];
    logic [1:0]  b_qi[$];
    logic [7:0]  c_qd[$];
    logic [1:0]  c_qi[$];
    logic [31:0] d_qd[$];
    logic [3:0]  d_qi[$];

    logic [31:0] w1 [9];
    logic [31:0] w2 [9];
    logic [7:0]  bv [4];
    logic [31:0] dv [4];

    always #5 clk = ~clk;

    maxpool_stream #(.DATA_W(8), .WIN(9), .CH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .signed_mode(a_sm), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef MAXPOOL_ARGMAX_EN
        , .out_idx(a_out_idx)
`endif
    );
    maxpool_stream #(.DATA_W(8), .WIN(4), .CH(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .signed_mode(b_sm), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef MAXPOOL_ARGMAX_EN
        , .out_idx(b_out_idx)
`endif
    );
    maxpool_stream #(.DATA_W(8), .WIN(3), .CH(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .signed_mode(c_sm), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data)
`ifdef MAXPOOL_ARGMAX_EN
        , .out_idx(c_out_idx)
`endif
    );
    maxpool_stream #(.DATA_W(8), .WIN(1), .CH(4)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .signed_mode(d_sm), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_data(d_out_data)
`ifdef MAXPOOL_ARGMAX_EN
        , .out_idx(d_out_idx)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one beat to instance inst and hold it until accepted (bounded).
    task automatic send(input int inst, input logic [31:0] d, input logic m);
        int   guard;
        logic rdy;
        guard = 0;
        rdy   = 1'b0;
        case (inst)
            0:       begin a_in_data = d;      a_sm = m; a_in_valid = 1'b1; end
            1:       begin b_in_data = d[7:0]; b_sm = m; b_in_valid = 1'b1; end
            2:       begin c_in_data = d[7:0]; c_sm = m; c_in_valid = 1'b1; end
            default: begin d_in_data = d;      d_sm = m; d_in_valid = 1'b1; end
        endcase
        while (!rdy) begin
            @(negedge clk);
            case (inst)
                0:       rdy = a_in_ready;
                1:       rdy = b_in_ready;
                2:       rdy = c_in_ready;
                default: rdy = d_in_ready;
            endcase
            @(posedge clk);
            #1;
            if (!rdy) begin
                guard++;
                if (guard >= 50) begin
                    n_total++;
                    $display("FAIL send_timeout: instance %0d not ready after %0d cycles", inst, guard);
                    rdy = 1'b1;
                end
            end
        end
        case (inst)
            0:       a_in_valid = 1'b0;
            1:       b_in_valid = 1'b0;
            2:       c_in_valid = 1'b0;
            default: d_in_valid = 1'b0;
        endcase
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((a_qd.size() + b_qd.size() + c_qd.size() + d_qd.size()) != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drained", 64'(a_qd.size() + b_qd.size() + c_qd.size() + d_qd.size()), 64'd0);
    endtask

    // Monitor A: data must match the head result on every valid cycle (stability while stalled).
    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_in_ready", 64'(a_in_ready), 64'(!a_out_valid || a_out_ready));
            if (a_out_valid) begin
                if (a_qd.size() == 0) begin
                    n_total++;
                    $display("FAIL a_unexpected: got 0x%0h expected no output", a_out_data);
                end else begin
                    chk("a_data", 64'(a_out_data), 64'(a_qd[0]));
`ifdef MAXPOOL_ARGMAX_EN
                    chk("a_idx", 64'(a_out_idx), 64'(a_qi[0]));
`endif
                    if (a_out_ready) begin
                        void'(a_qd.pop_front());
                        void'(a_qi.pop_front());
                    end
                end
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (mon_en && b_out_valid) begin
            if (b_qd.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected: got 0x%0h expected no output", b_out_data);
            end else begin
                chk("b_data", 64'(b_out_data), 64'(b_qd[0]));
`ifdef MAXPOOL_ARGMAX_EN
                chk("b_idx", 64'(b_out_idx), 64'(b_qi[0]));
`endif
                if (b_out_ready) begin
                    void'(b_qd.pop_front());
                    void'(b_qi.pop_front());
                end
            end
        end
    end

    // Monitor C.
    always @(negedge clk) begin
        if (mon_en && c_out_valid) begin
            if (c_qd.size() == 0) begin
                n_total++;
                $display("FAIL c_unexpected: got 0x%0h expected no output", c_out_data);
            end else begin
                chk("c_data", 64'(c_out_data), 64'(c_qd[0]));
`ifdef MAXPOOL_ARGMAX_EN
                chk("c_idx", 64'(c_out_idx), 64'(c_qi[0]));
`endif
                if (c_out_ready) begin
                    void'(c_qd.pop_front());
                    void'(c_qi.pop_front());
                end
            end
        end
    end

    // Monitor D: also counts consumed results for the one-per-cycle check.
    always @(negedge clk) begin
        if (mon_en && d_out_valid) begin
            if (d_qd.size() == 0) begin
                n_total++;
                $display("FAIL d_unexpected: got 0x%0h expected no output", d_out_data);
            end else begin
                chk("d_data", 64'(d_out_data), 64'(d_qd[0]));
`ifdef MAXPOOL_ARGMAX_EN
                chk("d_idx", 64'(d_out_idx), 64'(d_qi[0]));
`endif
                if (d_out_ready) begin
                    void'(d_qd.pop_front());
                    void'(d_qi.pop_front());
                    d_pops++;
                end
            end
        end
    end

    initial begin
        time t0;
        int  p0;
        // Window 1 (unsigned): lane0 3,7,1,9,9,2,0,5,4; lane1 all 55; lane2 1..8,FF; lane3 FE,10..80
        w1 = '{32'hFE015503, 32'h10025507, 32'h20035501, 32'h30045509, 32'h40055509,
               32'h50065502, 32'h60075500, 32'h70085505, 32'h80FF5504};
        // Window 2 (signed): lane0 max 01@8, lane1 80@0, lane2 7F@1 (tie at 2), lane3 FF@0
        w2 = '{32'hFF008080, 32'hFE7F80FF, 32'hFD7F80F0, 32'hFC108081, 32'hFB208090,
               32'hFA3080A0, 32'hF94080B0, 32'hF85080C0, 32'hF7608001};
        bv = '{8'h80, 8'hFF, 8'h10, 8'h7F};
        dv = '{32'h00FE8001, 32'h7FFF0080, 32'hFFFFFFFF, 32'h00000000};

        a_in_valid = 1'b0; a_in_data = 32'd0; a_sm = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 8'd0;  b_sm = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = 8'd0;  c_sm = 1'b0; c_out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_data = 32'd0; d_sm = 1'b0; d_out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_data",  64'(a_out_data),  64'd0);
        chk("rst_a_ready", 64'(a_in_ready),  64'd1);
        chk("rst_b_valid", 64'(b_out_valid), 64'd0);
        chk("rst_d_data",  64'(d_out_data),  64'd0);
        chk("rst_d_ready", 64'(d_in_ready),  64'd1);
`ifdef MAXPOOL_ARGMAX_EN
        chk("rst_a_idx",   64'(a_out_idx),   64'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Back-to-back windows with the consumer stalled at the first completion.
        fork
            begin
                int g;
                g = 0;
                a_out_ready = 1'b0;
                while (!a_out_valid && g < 100) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                if (g >= 100) begin
                    n_total++;
                    $display("FAIL stall_wait: got no out_valid expected one within %0d cycles", g);
                end
                repeat (5) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
            begin
                a_qd.push_back(32'hFEFF5509); a_qi.push_back(16'h0803);
                a_qd.push_back(32'hFF7F8001); a_qi.push_back(16'h0108);
                for (int j = 0; j < 9; j++) send(0, w1[j], 1'b0);
                for (int j = 0; j < 9; j++) send(0, w2[j], 1'b1);
            end
        join
        wait_drain();

        // Reset mid-window: 4 beats of EE are discarded, next 9 beats form a new window.
        for (int j = 0; j < 4; j++) send(0, 32'hEEEEEEEE, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_data",  64'(a_out_data),  64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_qd.push_back(32'hFEFF5509); a_qi.push_back(16'h0803);
        t0 = $time;
        for (int j = 0; j < 9; j++) send(0, w1[j], 1'b0);
        chk("a_throughput", 64'($time - t0), 64'd90);
        wait_drain();

        // Signed versus unsigned compare on the same beats.
        b_qd.push_back(8'h7F); b_qi.push_back(2'd3);
        for (int j = 0; j < 4; j++) send(1, 32'(bv[j]), 1'b1);
        b_qd.push_back(8'hFF); b_qi.push_back(2'd1);
        for (int j = 0; j < 4; j++) send(1, 32'(bv[j]), 1'b0);

        // Mode is taken from the first beat only.
        c_qd.push_back(8'h90); c_qi.push_back(2'd0);
        send(2, 32'h90, 1'b0); send(2, 32'h10, 1'b1); send(2, 32'h20, 1'b1);
        c_qd.push_back(8'h20); c_qi.push_back(2'd2);
        send(2, 32'h90, 1'b1); send(2, 32'h10, 1'b0); send(2, 32'h20, 1'b0);
        wait_drain();

        // WIN=1: every beat is a result, one per cycle.
        for (int j = 0; j < 4; j++) begin
            d_qd.push_back(dv[j]);
            d_qi.push_back(4'h0);
        end
        p0 = d_pops;
        t0 = $time;
        for (int j = 0; j < 4; j++) send(3, dv[j], 1'b0);
        chk("d_throughput", 64'($time - t0), 64'd40);
        @(posedge clk);
        #1;
        chk("d_results", 64'(d_pops - p0), 64'd4);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
